// File: rtl/seg7_to_bcd_capture.sv
// seg7_to_bcd_capture: recovers BCD digits from 7-segment drive lines.
// Stability-filtered sampling, change-only emit, valid/ready result port.
module seg7_to_bcd_capture #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:1] seg_in,
  input  logic       sample_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_bcd,
  output logic       out_blank,
  output logic       out_err,
  output logic       overrun,
  input  logic       clear_overrun
);

  localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [7:1]       cand;
  logic [CNT_W-1:0] cnt;
  logic [7:1]       last;
  logic             last_vld;
  logic             acc_q;
  logic [7:1]       acc_pat;

  logic             same;
  logic [CNT_W-1:0] cnt_nx;
  logic             accept;
  logic             emit;
  logic             deliver;
  logic [3:0]       dec_bcd;
  logic             dec_blank;
  logic             dec_err;

  // Stability filter next-state and accept detection
  always_comb begin
    same   = (seg_in == cand);
    cnt_nx = ONE;
    if (same) begin
      cnt_nx = (cnt >= STB) ? STB : cnt + ONE;
    end
    accept = sample_en && (cnt_nx == STB) && ((cnt < STB) || !same);
  end

  // Decode the accepted pattern into digit / blank / error
  always_comb begin
    dec_bcd   = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (acc_pat)
      7'b1111110: dec_bcd = 4'd0;
      7'b0110000: dec_bcd = 4'd1;
      7'b1101101: dec_bcd = 4'd2;
      7'b1111001: dec_bcd = 4'd3;
      7'b0110011: dec_bcd = 4'd4;
      7'b1011011: dec_bcd = 4'd5;
      7'b1011111: dec_bcd = 4'd6;
      7'b1110000: dec_bcd = 4'd7;
      7'b1111111: dec_bcd = 4'd8;
      7'b1111011: dec_bcd = 4'd9;
      7'b0000000: dec_blank = 1'b1;
      default:    dec_err = 1'b1;
    endcase
  end

  // Emit only on a change from the last accepted pattern
  always_comb begin
    emit    = acc_q && (!last_vld || (acc_pat != last));
    deliver = out_valid && out_ready;
  end

  // Sample filter state; frozen while sample_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= 7'b0;
      cnt     <= '0;
      acc_q   <= 1'b0;
      acc_pat <= 7'b0;
    end else begin
      acc_q <= accept;
      if (accept) acc_pat <= seg_in;
      if (sample_en) begin
        cand <= seg_in;
        cnt  <= cnt_nx;
      end
    end
  end

  // Result register, change tracking and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 7'b0;
      last_vld  <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= 4'h0;
      out_blank <= 1'b0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emit) begin
        last     <= acc_pat;
        last_vld <= 1'b1;
      end
      if (emit && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_bcd   <= dec_bcd;
        out_blank <= dec_blank;
        out_err   <= dec_err;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
      if (emit && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
